// File: rtl/serdes_fir_stream.sv
// Bit-serial receive, N-tap saturating FIR, XOR scramble, small FIFO and bit-serial transmit.
// RX and TX run concurrently; a word arriving at a full FIFO is dropped and flagged on ovf.
//
//   state | meaning
//   IDLE  | outputs quiet, pop the FIFO into the TX shifter when it holds a word
//   SHIFT | drive one data bit per cycle with so_vld high
//   DONE  | one-cycle done pulse between words
module serdes_fir_stream #(
    parameter int              W          = 8,
    parameter int              TAPS       = 4,
    parameter logic [TAPS*4-1:0] COEFFS   = {4'd1, 4'd2, 4'd2, 4'd1},
    parameter int              SHIFT      = 2,
    parameter logic [W-1:0]    KEY        = W'(8'hA5),
    parameter int              FIFO_DEPTH = 2,
    parameter bit              MSB_FIRST  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic si,
    input  logic si_vld,
    output logic so,
    output logic so_vld,
    output logic done,
    output logic ovf
);
    localparam int CW = $clog2(W);
    localparam int AW = W + 4 + $clog2(TAPS);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT_ST = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [W-1:0]  rx_sh, rx_nxt;
    logic [CW-1:0] rx_cnt;
    logic          rx_done;
    logic [W-1:0]  dly [TAPS];
    logic [AW-1:0] acc, acc_sh;
    logic [W-1:0]  y;
    logic [W-1:0]  fir_q;
    logic          fir_vld;
    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr, occ;
    logic          full, empty, push, pop;
    logic [1:0]    state;
    logic [W-1:0]  tx_sh;
    logic [CW-1:0] tx_cnt;

    always_comb begin
        rx_nxt = MSB_FIRST ? {rx_sh[W-2:0], si} : {si, rx_sh[W-1:1]};
    end

    // dly[0] is loaded with the completed word itself, so the FIR sees x_0..x_{TAPS-1} one edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sh   <= '0;
            rx_cnt  <= '0;
            rx_done <= 1'b0;
            for (int k = 0; k < TAPS; k++) dly[k] <= '0;
        end else if (!ena) begin
            rx_sh   <= '0;
            rx_cnt  <= '0;
            rx_done <= 1'b0;
            for (int k = 0; k < TAPS; k++) dly[k] <= '0;
        end else begin
            rx_done <= 1'b0;
            if (si_vld) begin
                rx_sh <= rx_nxt;
                if (rx_cnt == CW'(W - 1)) begin
                    rx_cnt  <= '0;
                    rx_done <= 1'b1;
                    dly[0]  <= rx_nxt;
                    for (int k = 1; k < TAPS; k++) dly[k] <= dly[k-1];
                end else begin
                    rx_cnt <= rx_cnt + CW'(1);
                end
            end
        end
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++)
            acc = acc + AW'(COEFFS[k*4 +: 4]) * AW'(dly[k]);
        acc_sh = acc >> SHIFT;
        y      = (|acc_sh[AW-1:W]) ? '1 : acc_sh[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fir_q   <= '0;
            fir_vld <= 1'b0;
        end else if (!ena) begin
            fir_q   <= '0;
            fir_vld <= 1'b0;
        end else begin
            fir_vld <= rx_done;
            if (rx_done) fir_q <= y;
        end
    end

    assign occ   = wr_ptr - rd_ptr;
    assign full  = (occ == (PW+1)'(FIFO_DEPTH));
    assign empty = (occ == '0);
    assign push  = fir_vld && !full;
    assign pop   = (state == IDLE) && !empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= fir_q ^ KEY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else if (!ena) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
            if (fir_vld && full) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            tx_sh  <= '0;
            tx_cnt <= '0;
            so     <= 1'b0;
            so_vld <= 1'b0;
            done   <= 1'b0;
        end else if (!ena) begin
            state  <= IDLE;
            tx_sh  <= '0;
            tx_cnt <= '0;
            so     <= 1'b0;
            so_vld <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    so     <= 1'b0;
                    so_vld <= 1'b0;
                    done   <= 1'b0;
                    if (!empty) begin
                        tx_sh  <= mem[rd_ptr[PW-1:0]];
                        tx_cnt <= CW'(W - 1);
                        state  <= SHIFT_ST;
                    end
                end
                SHIFT_ST: begin
                    so     <= MSB_FIRST ? tx_sh[tx_cnt] : tx_sh[CW'(W - 1) - tx_cnt];
                    so_vld <= 1'b1;
                    done   <= 1'b0;
                    if (tx_cnt == '0) state <= DONE;
                    else              tx_cnt <= tx_cnt - CW'(1);
                end
                DONE: begin
                    so     <= 1'b0;
                    so_vld <= 1'b0;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    so     <= 1'b0;
                    so_vld <= 1'b0;
                    done   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serdes_fir_stream.sv
// Bench for serdes_fir_stream: directed scenarios plus random words against a word-level FIR model.
module tb_serdes_fir_stream;
    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, si = 1'b0, si_vld = 1'b0;
    logic so, so_vld, done, ovf;
    logic so_l, so_vld_l, done_l, ovf_l;

    always #5 clk = ~clk;

    serdes_fir_stream dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .si(si), .si_vld(si_vld),
        .so(so), .so_vld(so_vld), .done(done), .ovf(ovf)
    );

    serdes_fir_stream #(.MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .ena(ena), .si(si), .si_vld(si_vld),
        .so(so_l), .so_vld(so_vld_l), .done(done_l), .ovf(ovf_l)
    );

    int checks = 0;
    int errors = 0;
    int dn_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rcv_q[$];
    logic [7:0] hist [4];
    int coef [4] = '{1, 2, 2, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // word-level reference: newest sample first, sum of products, divide by 4, clamp, scramble
    task automatic model_push(input logic [7:0] w);
        int acc;
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = w;
        acc = 0;
        for (int k = 0; k < 4; k++) acc += coef[k] * int'(hist[k]);
        acc = acc / 4;
        if (acc > 255) acc = 255;
        exp_q.push_back(8'(acc) ^ 8'hA5);
    endtask

    // output monitor: assembles MSB-first words and checks done follows the 8th bit
    logic ena_s = 1'b0;
    int mbits = 0;
    logic [7:0] mw = '0;
    logic prev_last = 1'b0;
    always @(posedge clk) ena_s <= ena;
    always @(negedge clk) begin
        if (!rst_n || !ena_s) begin
            mbits = 0;
            prev_last = 1'b0;
        end else begin
            if (done || prev_last) chk("done_timing", done, prev_last);
            if (done) dn_cnt++;
            prev_last = 1'b0;
            if (so_vld) begin
                mw = {mw[6:0], so};
                mbits++;
                if (mbits == 8) begin
                    rcv_q.push_back(mw);
                    mbits = 0;
                    prev_last = 1'b1;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; ena = 1'b0; si = 1'b0; si_vld = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) hist[k] = '0;
        exp_q.delete(); rcv_q.delete(); dn_cnt = 0;
        rst_n = 1'b1; ena = 1'b1;
        @(negedge clk);
    endtask

    // sends w MSB first; gap_len idle cycles inserted before bit gap_at; stop drops si_vld afterwards
    task automatic send_word(input logic [7:0] w, input int gap_at, input int gap_len,
                             input bit stop, input int tail);
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at)
                repeat (gap_len) begin
                    @(negedge clk); si_vld = 1'b0; si = 1'($urandom);
                end
            @(negedge clk); si = w[7-i]; si_vld = 1'b1;
        end
        if (stop) begin
            @(negedge clk); si_vld = 1'b0;
            repeat (tail) @(negedge clk);
        end
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (rcv_q.size() < exp_q.size() && t < 600) begin
            @(negedge clk); t++;
        end
        repeat (20) @(negedge clk);
        chk({tag, "_count"}, rcv_q.size(), exp_q.size());
        for (int i = 0; i < rcv_q.size() && i < exp_q.size(); i++)
            chk({tag, "_word"}, rcv_q[i], exp_q[i]);
        rcv_q.delete(); exp_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, observed hang expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        logic [7:0] w, lb, e;

        // reset state
        do_reset();
        chk("rst_so", so, 0);
        chk("rst_so_vld", so_vld, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_l_outs", {so_l, so_vld_l, done_l, ovf_l}, 0);

        // impulse
        repeat (2) begin
            model_push(8'h80);
            send_word(8'h80, 99, 0, 1'b1, 4);
        end
        drain("impulse");
        chk("impulse_done_cnt", dn_cnt, 2);

        // saturation
        do_reset();
        repeat (4) begin
            model_push(8'hFF);
            send_word(8'hFF, 99, 0, 1'b1, 4);
        end
        drain("sat");

        // gapped input and latency
        do_reset();
        model_push(8'h80);
        send_word(8'h80, 4, 3, 1'b1, 0);
        k = 1;
        while (!so_vld && k < 20) begin
            @(negedge clk); k++;
        end
        chk("gap_latency", k, 5);
        drain("gap");

        // random words with random gaps, paced so the FIFO never fills
        do_reset();
        repeat (10) begin
            w = 8'($urandom);
            model_push(w);
            send_word(w, $urandom_range(0, 8), $urandom_range(0, 2), 1'b1, $urandom_range(3, 6));
        end
        drain("rand");
        chk("rand_no_ovf", ovf, 0);

        // overflow: 16 back-to-back zero words
        do_reset();
        for (int i = 0; i < 16; i++) begin
            model_push(8'h00);
            send_word(8'h00, 99, 0, i == 15, 0);
        end
        repeat (250) @(negedge clk);
        chk("ovf_set", ovf, 1);
        chk("ovf_fewer_words", rcv_q.size() < 16, 1);
        chk("ovf_some_words", rcv_q.size() > 0, 1);
        for (int i = 0; i < rcv_q.size(); i++) chk("ovf_word", rcv_q[i], exp_q[i]);
        rcv_q.delete(); exp_q.delete();

        // flush mid-shift
        chk("pre_flush_ovf", ovf, 1);
        for (int i = 0; i < 3; i++) send_word(8'h00, 99, 0, i == 2, 0);
        chk("flush_mid_shift", so_vld, 1);
        ena = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        chk("flush_so", so, 0);
        chk("flush_so_vld", so_vld, 0);
        chk("flush_ovf", ovf, 0);
        for (int i = 0; i < 4; i++) hist[i] = '0;
        rcv_q.delete(); exp_q.delete();
        repeat (40) @(negedge clk);
        chk("flush_fifo_empty", rcv_q.size(), 0);
        model_push(8'h80);
        send_word(8'h80, 99, 0, 1'b1, 0);
        drain("post_flush");

        // LSB-first instance: serial 0,0,0,0,0,0,0,1 is word 0x80
        do_reset();
        model_push(8'h80);
        e = exp_q[0];
        send_word(8'h01, 99, 0, 1'b1, 0);
        k = 0;
        while (!so_vld_l && k < 30) begin
            @(negedge clk); k++;
        end
        chk("lsb_started", so_vld_l, 1);
        lb = '0;
        for (int i = 0; i < 8; i++) begin
            lb[i] = so_l;
            chk("lsb_bit_vld", so_vld_l, 1);
            @(negedge clk);
        end
        chk("lsb_word", lb, e);
        chk("lsb_done", done_l, 1);
        rcv_q.delete(); exp_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serdes_fir_stream.md
# serdes_fir_stream

- Parametrised successor to the single-byte serial FIR/XOR pipeline.
- Bit-serial words are deserialised on a qualified input and filtered by an N-tap FIR with per-tap coefficients and saturating output.
- Results are XOR-scrambled, buffered in a small FIFO, and re-serialised with a valid strobe.
- RX and TX run concurrently, so input is never stalled while a word shifts out; words arriving into a full FIFO are dropped and flagged.

## Interface
Parameters:
- `W`, 8: data word width (≥4).
- `TAPS`, 4: FIR tap count (≥1).
- `COEFFS`, {4'd1,4'd2,4'd2,4'd1}: packed TAPS×4-bit unsigned coefficients; tap 0 (newest sample) in the LSB nibble.
- `SHIFT`, 2: right-shift applied to the accumulator.
- `KEY`, 8'hA5 (W bits): XOR scramble key.
- `FIFO_DEPTH`, 2: output FIFO depth, power of two ≥2.
- `MSB_FIRST`, 1: bit order for both RX and TX; 1 = MSB first, 0 = LSB first.

Ports:
- `clk` in 1: clock. One clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: block enable; low = synchronous flush.
- `si` in 1: serial data in.
- `si_vld` in 1: `si` is sampled only when high.
- `so` out 1: serial data out.
- `so_vld` out 1: `so` carries a data bit.
- `done` out 1: one-cycle pulse after the last bit of each word.
- `ovf` out 1: sticky; a word was dropped because the FIFO was full.

## Operation
- **Reset** (`rst_n` low, async): all registers clear, including RX shift, bit count, delay line, FIR register, FIFO pointers and TX state. `so`, `so_vld`, `done` and `ovf` are all 0.
- **ena low** (synchronous): the same clear as reset, applied at each edge. Nothing is sampled or emitted.
- **RX**
  - On each edge with `ena && si_vld`, shift in `si`: MSB_FIRST gives `{rx[W-2:0],si}`; otherwise `{si,rx[W-1:1]}`.
  - After W qualified bits, the word completes and the count wraps to 0. Gaps in `si_vld` simply pause the count.
- **FIR**
  - On the edge after word completion: `acc = Σ COEFFS[k]·x_k`, where x_0 is the new word and x_1..x_{TAPS-1} are the previous delay-line entries (zero after reset/flush).
  - acc is full precision, with width W+4+clog2(TAPS).
  - `y = acc >> SHIFT`, saturated to 2^W−1 when it exceeds W bits.
  - The delay line shifts on the same edge.
- **Encrypt/push:** on the next edge, `y ^ KEY` is written to the FIFO. If the FIFO is full, the word is discarded, `ovf` is set, and FIFO contents are untouched.
- **TX FSM** (states IDLE, SHIFT, DONE):
  - IDLE with FIFO non-empty: pop into the TX shift register, load bit counter = W−1, go to SHIFT.
  - SHIFT: drive the next bit (MSB or LSB per MSB_FIRST) to `so` with `so_vld` = 1. At counter 0, go to DONE; else decrement.
  - DONE: `so` = 0, `so_vld` = 0, `done` = 1 for one cycle, go to IDLE.
  - In IDLE, `so`, `so_vld` and `done` are all 0.
- **Simultaneous push and pop:** both take effect; occupancy is unchanged. A push when full is dropped even if a pop occurs on the same edge.

## Timing
- Take edge N as the one sampling the last bit of a word:
  - fir register at N+1
  - FIFO write at N+2
  - TX load at N+3, if TX is idle
  - first `so` bit valid after N+4
  - last bit after N+3+W
  - `done` high after N+4+W
- TX cadence is W+2 cycles per word: `so_vld` is high for W cycles, then low for 2 cycles between back-to-back words.
- RX accepts one word per W qualified cycles. Sustained full-rate input therefore overflows the FIFO by design.
- `ovf` clears only on reset or `ena` low.

## Test plan
All scenarios use default parameters.
1. **Impulse:** after reset, send 0x80, then 0x80 → TX emits 0x85 (10000101), then 0xC5. `done` pulses once per word, exactly after the 8th `so_vld` cycle.
2. **Saturation:** send 0xFF four times → TX emits 0x9A, 0x1A, 0x5A, 0x5A (accumulators 255, 765, 1275, 1530; the last two saturate to 0xFF).
3. **Gapped input:** send 0x80 with `si_vld` low for 3 cycles between bits 3 and 4 → output 0x85 and no extra words. Latency from the last bit to the first `so` bit is 4 edges.
4. **Overflow:** stream 16 back-to-back words 0x00 with `si_vld` held high → `ovf` rises and stays high. Every emitted word is 0xA5, and fewer than 16 words are emitted.
5. **Flush:** drop `ena` mid-SHIFT for 1 cycle → `so`/`so_vld` go 0 on the next edge and the FIFO empties. `ovf` clears. A subsequent 0x80 yields 0x85, confirming the delay line was cleared.
6. **LSB_FIRST** (`MSB_FIRST`=0): send bits 0,0,0,0,0,0,0,1 → word 0x80 → `so` sequence 1,0,1,0,0,0,0,1 (0x85, LSB first).
